// File: rtl/piso_bit_serializer.sv
// Parallel-in, serial-out word serializer feeding the even-ones/even-zeros detector.
// Emits one bit per clock with framing (bit_valid, frame_last) and the per-word ones parity.
module piso_bit_serializer #(
    parameter int   WIDTH      = 8,
    parameter int   MSB_FIRST  = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] par_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             data_out,
    output logic             bit_valid,
    output logic             frame_last,
    output logic             ones_odd,
    output logic             busy
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic             r_data_out;
    logic             r_bit_valid;
    logic             r_frame_last;
    logic             r_ones_odd;

    logic             w_load;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // The head of the shift register is always the bit currently on data_out.
    function automatic logic head_bit(input logic [WIDTH-1:0] word);
        return (MSB_FIRST != 0) ? word[WIDTH-1] : word[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] word);
        return (MSB_FIRST != 0) ? {word[WIDTH-2:0], 1'b0} : {1'b0, word[WIDTH-1:1]};
    endfunction

    // Ready while idle, or on the last bit so a following word streams with no gap.
    assign load_ready  = (r_state == ST_IDLE) || r_frame_last;
    assign w_load      = load_valid && load_ready;
    assign w_shift_nxt = shift_one(r_shift);
    assign w_cnt_nxt   = r_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_data_out   <= IDLE_LEVEL;
            r_bit_valid  <= 1'b0;
            r_frame_last <= 1'b0;
            r_ones_odd   <= 1'b0;
        end else if (w_load) begin
            r_state      <= ST_SHIFT;
            r_shift      <= par_data;
            r_cnt        <= '0;
            r_data_out   <= head_bit(par_data);
            r_bit_valid  <= 1'b1;
            r_frame_last <= 1'b0;
            r_ones_odd   <= ^par_data;
        end else if (r_state == ST_SHIFT) begin
            if (r_frame_last) begin
                // Word finished with no successor; parity stays visible.
                r_state      <= ST_IDLE;
                r_cnt        <= '0;
                r_data_out   <= IDLE_LEVEL;
                r_bit_valid  <= 1'b0;
                r_frame_last <= 1'b0;
            end else begin
                r_shift      <= w_shift_nxt;
                r_cnt        <= w_cnt_nxt;
                r_data_out   <= head_bit(w_shift_nxt);
                r_frame_last <= (w_cnt_nxt == LAST_IDX);
            end
        end
    end

    assign data_out   = r_data_out;
    assign bit_valid  = r_bit_valid;
    assign frame_last = r_frame_last;
    assign ones_odd   = r_ones_odd;
    assign busy       = r_bit_valid;

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Scoreboard bench for piso_bit_serializer: one MSB-first and one LSB-first instance,
// expected bit streams queued at each accepted load and compared every cycle.
module tb_piso_bit_serializer;

    typedef struct packed {
        logic d;
        logic last;
        logic odd;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pd0, pd1;
    logic       lv0, lv1;
    logic       lr0, dout0, bv0, fl0, oo0, bz0;
    logic       lr1, dout1, bv1, fl1, oo1, bz1;

    exp_t q0[$];
    exp_t q1[$];
    logic m_odd0, m_odd1;
    bit   acc0, acc1;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) u_msb (
        .clk(clk), .reset(reset), .par_data(pd0), .load_valid(lv0), .load_ready(lr0),
        .data_out(dout0), .bit_valid(bv0), .frame_last(fl0), .ones_odd(oo0), .busy(bz0)
    );

    piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .par_data(pd1), .load_valid(lv1), .load_ready(lr1),
        .data_out(dout1), .bit_valid(bv1), .frame_last(fl1), .ones_odd(oo1), .busy(bz1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic push_word(input int which, input logic [7:0] w);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.d    = (which == 0) ? w[7-i] : w[i];
            e.last = (i == 7);
            e.odd  = ^w;
            if (which == 0) q0.push_back(e);
            else            q1.push_back(e);
        end
        if (which == 0) m_odd0 = ^w;
        else            m_odd1 = ^w;
    endtask

    task automatic sample(input int which);
        exp_t  e;
        logic  d, bv, fl, oo, lr, bz, m;
        bit    have, rdy;
        string p;
        e = '0;
        if (which == 0) begin
            p = "msb"; d = dout0; bv = bv0; fl = fl0; oo = oo0; lr = lr0; bz = bz0; m = m_odd0;
            have = (q0.size() != 0);
            if (have) e = q0.pop_front();
            rdy = (q0.size() == 0);
        end else begin
            p = "lsb"; d = dout1; bv = bv1; fl = fl1; oo = oo1; lr = lr1; bz = bz1; m = m_odd1;
            have = (q1.size() != 0);
            if (have) e = q1.pop_front();
            rdy = (q1.size() == 0);
        end
        if (have) begin
            chk({p, "_data"},  d,  e.d);
            chk({p, "_last"},  fl, e.last);
            chk({p, "_odd"},   oo, e.odd);
            chk({p, "_valid"}, bv, 1);
            chk({p, "_busy"},  bz, 1);
        end else begin
            chk({p, "_idle_data"},  d,  1'b0);
            chk({p, "_idle_valid"}, bv, 0);
            chk({p, "_idle_last"},  fl, 0);
            chk({p, "_idle_odd"},   oo, m);
            chk({p, "_idle_busy"},  bz, 0);
        end
        chk({p, "_ready"}, lr, rdy);
    endtask

    task automatic step();
        bit         a0, a1;
        logic [7:0] w0, w1;
        a0 = lv0 && reset && (q0.size() == 0);
        a1 = lv1 && reset && (q1.size() == 0);
        w0 = pd0;
        w1 = pd1;
        @(posedge clk);
        if (a0) push_word(0, w0);
        if (a1) push_word(1, w1);
        acc0 = a0;
        acc1 = a1;
        #1;
        sample(0);
        sample(1);
    endtask

    // Present a word and hold load_valid until the model says it was taken.
    task automatic send(input int which, input logic [7:0] w);
        bit got;
        got = 1'b0;
        if (which == 0) begin pd0 = w; lv0 = 1'b1; end
        else            begin pd1 = w; lv1 = 1'b1; end
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            got = (which == 0) ? acc0 : acc1;
        end
    endtask

    initial begin
        reset = 1'b0;
        lv0 = 1'b0; lv1 = 1'b0; pd0 = '0; pd1 = '0;
        m_odd0 = 1'b0; m_odd1 = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        sample(0);
        sample(1);
        @(negedge clk);
        reset = 1'b1;

        repeat (10) step();

        pd0 = 8'hA5; lv0 = 1'b1;
        pd1 = 8'h01; lv1 = 1'b1;
        step();
        lv0 = 1'b0; lv1 = 1'b0;
        repeat (10) step();

        send(0, 8'hFF);
        send(0, 8'h0F);
        lv0 = 1'b0;
        repeat (18) step();

        send(0, 8'hA5);
        lv0 = 1'b0;
        repeat (2) step();
        send(0, 8'h3C);
        lv0 = 1'b0;
        repeat (10) step();

        send(0, 8'hA5);
        lv0 = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        q0.delete(); q1.delete();
        m_odd0 = 1'b0; m_odd1 = 1'b0;
        #1;
        sample(0);
        sample(1);
        @(posedge clk);
        #1;
        sample(0);
        sample(1);
        @(negedge clk);
        reset = 1'b1;
        send(0, 8'h80);
        lv0 = 1'b0;
        send(1, 8'h80);
        lv1 = 1'b0;
        repeat (10) step();

        for (int c = 0; c < 400; c++) begin
            lv0 = ($urandom_range(0, 3) != 0);
            lv1 = ($urandom_range(0, 3) != 0);
            pd0 = 8'($urandom);
            pd1 = 8'($urandom);
            step();
        end
        lv0 = 1'b0; lv1 = 1'b0;
        repeat (12) step();
        chk("msb_drain", q0.size(), 0);
        chk("lsb_drain", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
